// File: rtl/sobel_magnitude.sv
// Sobel final stage: Gx/Gy from partial sums, |Gx|+|Gy| saturated per pixel, skid-buffered strobe/busy.
// Define SOBEL_THRESHOLD_EN to emit a binarized edge map (mag >= THRESHOLD) instead of the magnitude.

module sobel_magnitude_lane #(
  parameter int DATAWIDTH = 8,
  parameter int THRESHOLD = 128
) (
  input  logic                     clk,
  input  logic                     ARESET,
  input  logic                     ld1,
  input  logic                     ld2,
  input  logic [2*DATAWIDTH-1:0]   x_0,
  input  logic [2*DATAWIDTH-1:0]   x_2,
  input  logic [2*DATAWIDTH-1:0]   y_0,
  input  logic [2*DATAWIDTH-1:0]   y_2,
  output logic [DATAWIDTH-1:0]     pix
);
  localparam int W = 2*DATAWIDTH;
`ifdef SOBEL_THRESHOLD_EN
  localparam bit BINARIZE = 1'b1;
`else
  localparam bit BINARIZE = 1'b0;
`endif
  // Both modes reduce to one compare: saturation fires at 2^DATAWIDTH, binarization at THRESHOLD.
  localparam logic [W+1:0] LIMIT = BINARIZE ? (W+2)'(THRESHOLD) : (W+2)'(2**DATAWIDTH);

  logic [W:0]         gx, gy;
  logic [W+1:0]       ax, ay, mag;
  logic [DATAWIDTH-1:0] pix_d;

  always_comb begin
    ax    = gx[W] ? {1'b0, ~gx + {{W{1'b0}}, 1'b1}} : {1'b0, gx};
    ay    = gy[W] ? {1'b0, ~gy + {{W{1'b0}}, 1'b1}} : {1'b0, gy};
    mag   = ax + ay;
    pix_d = (mag >= LIMIT) ? '1 : (BINARIZE ? '0 : mag[DATAWIDTH-1:0]);
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      gx  <= '0;
      gy  <= '0;
      pix <= '0;
    end else begin
      if (ld1) begin
        gx <= {1'b0, x_2} - {1'b0, x_0};
        gy <= {1'b0, y_2} - {1'b0, y_0};
      end
      if (ld2) pix <= pix_d;
    end
  end
endmodule

module sobel_magnitude #(
  parameter int PIXEL     = 3,
  parameter int DATAWIDTH = 8,
  parameter int THRESHOLD = 128
) (
  input  logic                           clk,
  input  logic                           ARESET,
  input  logic [2*DATAWIDTH*PIXEL-1:0]   packed_in_x_0,
  input  logic [2*DATAWIDTH*PIXEL-1:0]   packed_in_x_2,
  input  logic [2*DATAWIDTH*PIXEL-1:0]   packed_in_y_0,
  input  logic [2*DATAWIDTH*PIXEL-1:0]   packed_in_y_2,
  input  logic                           i_strobe,
  output logic                           o_busy,
  input  logic                           in_tlast,
  output logic [DATAWIDTH*PIXEL-1:0]     packed_out,
  output logic                           o_strobe,
  input  logic                           i_busy,
  output logic                           out_tlast
);
  localparam int W = 2*DATAWIDTH;

  typedef struct packed {
    logic [PIXEL-1:0][W-1:0] x0;
    logic [PIXEL-1:0][W-1:0] x2;
    logic [PIXEL-1:0][W-1:0] y0;
    logic [PIXEL-1:0][W-1:0] y2;
    logic                    tlast;
  } beat_t;

  beat_t in_beat, skid, src;
  logic  skid_vld, in_vld, acc, adv, tlast1;
  logic  [2:1] vld_pipe;
  logic  [PIXEL-1:0][DATAWIDTH-1:0] pix;

  assign in_beat  = {packed_in_x_0, packed_in_x_2, packed_in_y_0, packed_in_y_2, in_tlast};
  assign acc      = i_strobe && !o_busy;
  assign adv      = !o_strobe || !i_busy;
  // A full skid always has priority: o_busy is high then, so no new beat competes with it.
  assign src      = skid_vld ? skid : in_beat;
  assign in_vld   = skid_vld || acc;
  assign o_strobe = vld_pipe[2];
  assign packed_out = pix;

  always_ff @(posedge clk) begin
    if (ARESET) begin
      skid_vld  <= 1'b0;
      skid      <= '0;
      o_busy    <= 1'b1;
      vld_pipe  <= '0;
      tlast1    <= 1'b0;
      out_tlast <= 1'b0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[1], in_vld};
      tlast1    <= in_vld && src.tlast;
      out_tlast <= tlast1;
      skid_vld  <= 1'b0;
      o_busy    <= 1'b0;
    end else if (acc) begin
      skid_vld  <= 1'b1;
      skid      <= in_beat;
      o_busy    <= 1'b1;
    end
  end

  for (genvar k = 0; k < PIXEL; k++) begin : g_lane
    sobel_magnitude_lane #(
      .DATAWIDTH(DATAWIDTH),
      .THRESHOLD(THRESHOLD)
    ) u_lane (
      .clk    (clk),
      .ARESET (ARESET),
      .ld1    (adv && in_vld),
      .ld2    (adv && vld_pipe[1]),
      .x_0    (src.x0[k]),
      .x_2    (src.x2[k]),
      .y_0    (src.y0[k]),
      .y_2    (src.y2[k]),
      .pix    (pix[k])
    );
  end
endmodule

// File: tb/tb_sobel_magnitude.sv
// Directed bench for sobel_magnitude: reset, single beats, saturation, backpressure, tlast, mid-stream reset.
module tb_sobel_magnitude;
  localparam int P = 3, DW = 8, W = 16;

  logic clk = 1'b0, ARESET = 1'b1;
  logic [P-1:0][W-1:0] x0, x2, y0, y2;
  logic i_strobe = 1'b0, in_tlast = 1'b0, i_busy = 1'b0;
  logic o_busy, o_strobe, out_tlast;
  logic [P*DW-1:0] packed_out;
  int checks = 0, errors = 0;

`ifdef SOBEL_THRESHOLD_EN
  localparam logic [31:0] EXP_SINGLE = 32'd0;
`else
  localparam logic [31:0] EXP_SINGLE = 32'd11;
`endif

  always #5 clk = ~clk;

  sobel_magnitude #(.PIXEL(P), .DATAWIDTH(DW), .THRESHOLD(128)) dut (
    .clk(clk), .ARESET(ARESET),
    .packed_in_x_0(x0), .packed_in_x_2(x2), .packed_in_y_0(y0), .packed_in_y_2(y2),
    .i_strobe(i_strobe), .o_busy(o_busy), .in_tlast(in_tlast),
    .packed_out(packed_out), .o_strobe(o_strobe), .i_busy(i_busy), .out_tlast(out_tlast)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_px();
    x0 = '0; x2 = '0; y0 = '0; y2 = '0;
  endtask

  // Beat i: pixel0 gx=i+1, pixel1 gx=-(i+20), pixel2 gy=-(300+i) which always saturates.
  task automatic drive_beat(input int i);
    clear_px();
    x2[0] = 16'(i + 1);
    x0[1] = 16'(i + 20);
    y0[2] = 16'(300 + i);
  endtask

  function automatic logic [31:0] exp_beat(input int i);
`ifdef SOBEL_THRESHOLD_EN
    return {8'd0, 8'd255, 8'd0, 8'd0};
`else
    return {8'd0, 8'd255, 8'(i + 20), 8'(i + 1)};
`endif
  endfunction

  task automatic run_stream(input int n, input int st, input int sl, input int tl);
    int in_i = 0, out_i = 0, cyc = 0;
    bit took;
    while (out_i < n && cyc < 200) begin
      i_busy = (cyc >= st && cyc < st + sl);
      if (cyc == st + 1)      check("busy_rise", o_busy, 1);
      if (cyc == st + sl + 1) check("busy_fall", o_busy, 0);
      if (o_strobe) begin
        check("stream_data", packed_out, exp_beat(out_i));
        check("stream_tlast", out_tlast, (out_i == tl) ? 1 : 0);
        if (!i_busy) out_i++;
      end
      if (in_i < n) begin
        drive_beat(in_i);
        i_strobe = 1'b1;
        in_tlast = (in_i == tl);
      end else begin
        i_strobe = 1'b0;
        in_tlast = 1'b0;
      end
      took = (in_i < n) && !o_busy;
      step();
      cyc++;
      if (took) in_i++;
    end
    check("stream_count", out_i, n);
    i_strobe = 1'b0; in_tlast = 1'b0; i_busy = 1'b0;
    repeat (3) begin
      step();
      check("stream_no_dup", o_strobe, 0);
    end
  endtask

  initial begin
    clear_px();
    repeat (3) step();
    check("rst_busy", o_busy, 1);
    check("rst_strobe", o_strobe, 0);
    check("rst_tlast", out_tlast, 0);
    check("rst_data", packed_out, 0);
    ARESET = 1'b0;
    step();
    check("busy_release", o_busy, 0);
    check("idle_strobe", o_strobe, 0);
    check("idle_data", packed_out, 0);

    // Single beat: gx=4-10, gy=8-3 -> 11
    x0[0] = 16'd10; x2[0] = 16'd4; y0[0] = 16'd3; y2[0] = 16'd8;
    i_strobe = 1'b1;
    step();
    i_strobe = 1'b0;
    check("single_lat1", o_strobe, 0);
    step();
    check("single_strobe", o_strobe, 1);
    check("single_data", packed_out, EXP_SINGLE);
    step();
    check("single_once", o_strobe, 0);

    // Saturation: |-1020|+|1020| = 2040 -> 255 in both modes
    clear_px();
    x0[0] = 16'd1020; y2[0] = 16'd1020;
    i_strobe = 1'b1;
    step();
    i_strobe = 1'b0;
    step();
    check("sat_strobe", o_strobe, 1);
    check("sat_data", packed_out, 255);
    step();
    check("sat_once", o_strobe, 0);

    run_stream(8, 3, 5, -1);
    run_stream(6, 4, 3, 3);

    // Fill output, stage 1 and skid, then reset
    i_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_beat(i);
      i_strobe = 1'b1;
      step();
    end
    check("full_busy", o_busy, 1);
    check("full_strobe", o_strobe, 1);
    ARESET = 1'b1;
    i_strobe = 1'b0;
    step();
    check("midrst_strobe", o_strobe, 0);
    check("midrst_busy", o_busy, 1);
    check("midrst_tlast", out_tlast, 0);
    ARESET = 1'b0;
    i_busy = 1'b0;
    repeat (5) begin
      step();
      check("no_stale", o_strobe, 0);
    end
    check("post_rst_busy", o_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
